ucisc_register_file: RTL and testbench
======================================

// Module: ucisc_register_file
// PURPOSE
//  uCISC architectural register file: PC, r1-r3, rb1-rb3, flags and banking control.
//  Decodes 4-bit source/destination selectors into two combinational read ports and one write port.
//  Sequenced by the core's 2-bit step counter; sits between instruction decode, ALU and memory address logic.
// PARAMETERS
//  WIDTH        16      data/register width
//  BANK_RESET   16'h00E0 reset value of banking register (rb1-rb3 banked)
// PORTS
//  clock              in   1   system clock, rising-edge active
//  reset              in   1   asynchronous, active-low reset
//  step               in   2   instruction step; 1 = latch selectors, 3 = commit
//  desired_source     in   4   source selector
//  desired_destination in  4   destination selector
//  write_value        in   16  data written to destination at step 3
//  write_enable       in   1   enable destination write at step 3
//  push               in   1   pre-decrement destination pointer at step 1
//  pop                in   1   post-increment source pointer at step 3
//  inc_enable         in   1   post-increment destination pointer at step 3
//  flags_in           in   16  ALU flags
//  write_flags        in   1   load flags from flags_in at step 3
//  source_value       out  16  value of latched source selector
//  destination_value  out  16  value of latched destination selector
//  pc                 out  16  program counter
//  flags              out  16  flags register
//  banking            out  16  banking control register
//  source_banked      out  1   latched source is a banked memory pointer
//  destination_banked out  1   latched destination is a banked memory pointer
// BEHAVIOUR
//  Selector map: 0 PC; 1-3 r1-r3 (memory mode); 4 immediate (reads 0, writes ignored);
//   5-7 r1-r3 (register mode); 8 flags; 9-B rb1-rb3 (memory mode); C banking; D-F rb1-rb3 (register).
//  Memory and register modes of one register are the same storage; reads return register contents.
//  Writes through memory modes (1-3, 9-B) never modify the register (the memory is written instead).
//  Reset (async, reset=0): all registers, pc, flags and latched selectors = 0; banking = BANK_RESET.
//  Step 1 rising edge: latch both selectors; if push and dest is memory mode, that register -= 1.
//  Step 3 rising edge, priority high->low:
//   - write_enable & dest in {0,5-7,8,C,D-F}: target <= write_value; write_flags overrides dest 8.
//   - write_flags: flags <= flags_in.
//   - pop & source memory mode: source register += 1, unless written this edge.
//   - inc_enable & !push & dest memory mode: dest register += 1, unless written this edge.
//   - PC <= PC + 1 unless written this edge.
//  Steps 0, 2: no state change.
//  Read ports are combinational from latched selectors; same-edge writes are visible after the edge.
//  *_banked = banking[reg index] for memory-mode selectors (r1-r3 -> bits 1-3, rb1-rb3 -> bits 5-7); 0 otherwise.
//  Arithmetic is modulo 2^16: FFFF+1 = 0000, 0000-1 = FFFF.
// STRUCTURE
//  Shared package: selector encodings (SEL_PC, SEL_R1M.., SEL_IMM, SEL_FLAGS, SEL_BANK), step codes, WIDTH.
//  One sub-module: ucisc_sel_decode (selector -> register index, mode, writable flag).
// TESTING
//  Reset: assert reset=0 -> pc=0000, flags=0000, banking=00E0, source_value=0000.
//  PC write: dest 0, write_value FFFF, step 3 edge -> pc=FFFF; next step-3 edge with no write -> pc=0000.
//  Register vs memory write: dest 5 write FFF1 -> dest 1 reads FFF1;
//   dest 1 write 5555 -> value stays FFF1, destination_banked=0.
//  Banked regs: dest D write FFF9 -> dest 9 reads FFF9, destination_banked=1; same for E/A, F/B.
//  Flags: dest 8, write_enable=1, write_flags=1, flags_in FF00, write_value 5555 -> flags=FF00;
//   repeat with write_flags=0 -> flags=5555.
//  Stack: dest 1 (r1=0010) push at step 1 -> r1=000F;
//   source 1 with pop at step 3 -> r1 increments; selector 4 always reads 0000.

Source files
------------

// File: rtl/ucisc_register_file_pkg.sv
// Shared definitions for the uCISC register file: data width, selector encodings,
// step codes and the decoded-selector record.
package ucisc_register_file_pkg;

  localparam int WIDTH = 16;
  localparam logic [WIDTH-1:0] BANK_RESET_DEFAULT = 16'h00E0;

  typedef logic [3:0] sel_t;

  localparam sel_t SEL_PC    = 4'h0;
  localparam sel_t SEL_R1M   = 4'h1;
  localparam sel_t SEL_R2M   = 4'h2;
  localparam sel_t SEL_R3M   = 4'h3;
  localparam sel_t SEL_IMM   = 4'h4;
  localparam sel_t SEL_R1    = 4'h5;
  localparam sel_t SEL_R2    = 4'h6;
  localparam sel_t SEL_R3    = 4'h7;
  localparam sel_t SEL_FLAGS = 4'h8;
  localparam sel_t SEL_RB1M  = 4'h9;
  localparam sel_t SEL_RB2M  = 4'hA;
  localparam sel_t SEL_RB3M  = 4'hB;
  localparam sel_t SEL_BANK  = 4'hC;
  localparam sel_t SEL_RB1   = 4'hD;
  localparam sel_t SEL_RB2   = 4'hE;
  localparam sel_t SEL_RB3   = 4'hF;

  typedef enum logic [1:0] {
    STEP_IDLE   = 2'd0,
    STEP_LATCH  = 2'd1,
    STEP_EXEC   = 2'd2,
    STEP_COMMIT = 2'd3
  } step_e;

  typedef enum logic [2:0] {
    KIND_PC,
    KIND_GPR,
    KIND_IMM,
    KIND_FLAGS,
    KIND_BANK
  } kind_e;

  // idx is the general-register slot (1-3 = r1-r3, 5-7 = rb1-rb3), which is
  // also the banking bit that governs that register.
  typedef struct packed {
    kind_e      kind;
    logic [2:0] idx;
    logic       mem;
    logic       writable;
  } sel_info_t;

endpackage

// File: rtl/ucisc_register_file_if.sv
// Control/data bus between the core sequencer and the register file.
interface ucisc_register_file_if;
  import ucisc_register_file_pkg::*;

  logic [1:0]       step;
  sel_t             desired_source;
  sel_t             desired_destination;
  logic [WIDTH-1:0] write_value;
  logic             write_enable;
  logic             push;
  logic             pop;
  logic             inc_enable;
  logic [WIDTH-1:0] flags_in;
  logic             write_flags;
  logic [WIDTH-1:0] source_value;
  logic [WIDTH-1:0] destination_value;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] flags;
  logic [WIDTH-1:0] banking;
  logic             source_banked;
  logic             destination_banked;

  modport master (
    output step, desired_source, desired_destination, write_value, write_enable,
           push, pop, inc_enable, flags_in, write_flags,
    input  source_value, destination_value, pc, flags, banking,
           source_banked, destination_banked
  );

  modport slave (
    input  step, desired_source, desired_destination, write_value, write_enable,
           push, pop, inc_enable, flags_in, write_flags,
    output source_value, destination_value, pc, flags, banking,
           source_banked, destination_banked
  );

endinterface

// File: rtl/ucisc_sel_decode.sv
// Maps a 4-bit selector to its storage kind, register slot, addressing mode
// and whether a register write through it lands in the register.
module ucisc_sel_decode
  import ucisc_register_file_pkg::*;
(
  input  sel_t      sel,
  output sel_info_t info
);

  always_comb begin
    info = '{kind: KIND_IMM, idx: 3'd0, mem: 1'b0, writable: 1'b0};
    case (sel)
      SEL_PC: begin
        info.kind     = KIND_PC;
        info.writable = 1'b1;
      end
      SEL_R1M, SEL_R2M, SEL_R3M: begin
        info.kind = KIND_GPR;
        info.idx  = sel[2:0];
        info.mem  = 1'b1;
      end
      SEL_R1, SEL_R2, SEL_R3: begin
        info.kind     = KIND_GPR;
        info.idx      = sel[2:0] - 3'd4;
        info.writable = 1'b1;
      end
      SEL_FLAGS: begin
        info.kind     = KIND_FLAGS;
        info.writable = 1'b1;
      end
      SEL_RB1M, SEL_RB2M, SEL_RB3M: begin
        info.kind = KIND_GPR;
        info.idx  = sel[2:0] + 3'd4;
        info.mem  = 1'b1;
      end
      SEL_BANK: begin
        info.kind     = KIND_BANK;
        info.writable = 1'b1;
      end
      SEL_RB1, SEL_RB2, SEL_RB3: begin
        info.kind     = KIND_GPR;
        info.idx      = sel[2:0];
        info.writable = 1'b1;
      end
      default: ; // SEL_IMM: reads zero, never written
    endcase
  end

endmodule

// File: rtl/ucisc_register_file.sv
// uCISC architectural register file: PC, r1-r3, rb1-rb3, flags and banking,
// with two combinational read ports and a step-sequenced write port.
module ucisc_register_file
  import ucisc_register_file_pkg::*;
#(
  parameter logic [WIDTH-1:0] BANK_RESET = BANK_RESET_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  ucisc_register_file_if.slave  bus
);

  sel_t             src_sel_reg, src_sel_next;
  sel_t             dst_sel_reg, dst_sel_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [WIDTH-1:0] flags_reg, flags_next;
  logic [WIDTH-1:0] bank_reg, bank_next;
  logic [WIDTH-1:0] gpr_reg  [8];
  logic [WIDTH-1:0] gpr_next [8];

  sel_info_t src_info, dst_info, push_info;
  logic      wr_en, wr_gpr;

  ucisc_sel_decode u_src_dec  (.sel(src_sel_reg),             .info(src_info));
  ucisc_sel_decode u_dst_dec  (.sel(dst_sel_reg),             .info(dst_info));
  ucisc_sel_decode u_push_dec (.sel(bus.desired_destination), .info(push_info));

  // Memory-mode destinations are never writable, so a register write can only
  // collide with a pop of the same register; the write wins by being applied last.
  always_comb begin
    src_sel_next = src_sel_reg;
    dst_sel_next = dst_sel_reg;
    pc_next      = pc_reg;
    flags_next   = flags_reg;
    bank_next    = bank_reg;
    for (int i = 0; i < 8; i++) gpr_next[i] = gpr_reg[i];
    wr_en  = bus.write_enable && dst_info.writable;
    wr_gpr = wr_en && (dst_info.kind == KIND_GPR);

    if (bus.step == STEP_LATCH) begin
      src_sel_next = bus.desired_source;
      dst_sel_next = bus.desired_destination;
      if (bus.push && push_info.kind == KIND_GPR && push_info.mem)
        gpr_next[push_info.idx] = gpr_reg[push_info.idx] - 1'b1;
    end else if (bus.step == STEP_COMMIT) begin
      pc_next = (wr_en && dst_info.kind == KIND_PC) ? bus.write_value : pc_reg + 1'b1;
      if (bus.write_flags)
        flags_next = bus.flags_in;
      else if (wr_en && dst_info.kind == KIND_FLAGS)
        flags_next = bus.write_value;
      if (wr_en && dst_info.kind == KIND_BANK)
        bank_next = bus.write_value;
      if (bus.pop && src_info.kind == KIND_GPR && src_info.mem)
        gpr_next[src_info.idx] = gpr_reg[src_info.idx] + 1'b1;
      if (bus.inc_enable && !bus.push && dst_info.kind == KIND_GPR && dst_info.mem)
        gpr_next[dst_info.idx] = gpr_reg[dst_info.idx] + 1'b1;
      if (wr_gpr)
        gpr_next[dst_info.idx] = bus.write_value;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      src_sel_reg <= SEL_PC;
      dst_sel_reg <= SEL_PC;
      pc_reg      <= '0;
      flags_reg   <= '0;
      bank_reg    <= BANK_RESET;
    end else begin
      src_sel_reg <= src_sel_next;
      dst_sel_reg <= dst_sel_next;
      pc_reg      <= pc_next;
      flags_reg   <= flags_next;
      bank_reg    <= bank_next;
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_gpr
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) gpr_reg[gi] <= '0;
      else        gpr_reg[gi] <= gpr_next[gi];
    end
  end

  always_comb begin
    bus.source_value      = '0;
    bus.destination_value = '0;
    case (src_info.kind)
      KIND_PC:    bus.source_value = pc_reg;
      KIND_GPR:   bus.source_value = gpr_reg[src_info.idx];
      KIND_FLAGS: bus.source_value = flags_reg;
      KIND_BANK:  bus.source_value = bank_reg;
      default:    bus.source_value = '0;
    endcase
    case (dst_info.kind)
      KIND_PC:    bus.destination_value = pc_reg;
      KIND_GPR:   bus.destination_value = gpr_reg[dst_info.idx];
      KIND_FLAGS: bus.destination_value = flags_reg;
      KIND_BANK:  bus.destination_value = bank_reg;
      default:    bus.destination_value = '0;
    endcase
  end

  assign bus.pc                 = pc_reg;
  assign bus.flags              = flags_reg;
  assign bus.banking            = bank_reg;
  assign bus.source_banked      = src_info.kind == KIND_GPR && src_info.mem && bank_reg[src_info.idx];
  assign bus.destination_banked = dst_info.kind == KIND_GPR && dst_info.mem && bank_reg[dst_info.idx];

endmodule

// File: tb/tb_ucisc_register_file.sv
// Scenario-driven bench for ucisc_register_file with a queue-based scoreboard.
module tb_ucisc_register_file;

  logic clock = 1'b0;
  logic reset = 1'b0;

  ucisc_register_file_if ifc ();

  ucisc_register_file dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          fails  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got, exp;
  logic [15:0] m_pc  = 16'h0000;
  logic [3:0]  cur_dst = 4'h0;

  task automatic clear_inputs();
    ifc.step                = 2'd0;
    ifc.desired_source      = 4'h0;
    ifc.desired_destination = 4'h0;
    ifc.write_value         = 16'h0000;
    ifc.write_enable        = 1'b0;
    ifc.push                = 1'b0;
    ifc.pop                 = 1'b0;
    ifc.inc_enable          = 1'b0;
    ifc.flags_in            = 16'h0000;
    ifc.write_flags         = 1'b0;
  endtask

  // Steps 0 and 1; returns at the falling edge after the latch edge.
  task automatic latch(input logic [3:0] src, input logic [3:0] dst, input logic psh);
    @(negedge clock);
    ifc.step = 2'd0;
    @(negedge clock);
    ifc.step                = 2'd1;
    ifc.desired_source      = src;
    ifc.desired_destination = dst;
    ifc.push                = psh;
    cur_dst                 = dst;
    @(negedge clock);
    ifc.step = 2'd2;
    ifc.push = 1'b0;
  endtask

  // Step 3; returns at the falling edge after the commit edge.
  task automatic commit(input logic [15:0] wv, input logic we, input logic pp,
                        input logic inc, input logic [15:0] fi, input logic wf);
    ifc.step         = 2'd3;
    ifc.write_value  = wv;
    ifc.write_enable = we;
    ifc.pop          = pp;
    ifc.inc_enable   = inc;
    ifc.flags_in     = fi;
    ifc.write_flags  = wf;
    @(negedge clock);
    clear_inputs();
    if (we && cur_dst == 4'h0) m_pc = wv;
    else                       m_pc = m_pc + 16'h0001;
    $display("txn dst=%h wv=%h we=%b pop=%b inc=%b wf=%b -> pc=%h src=%h dst_val=%h flags=%h",
             cur_dst, wv, we, pp, inc, wf, ifc.pc, ifc.source_value, ifc.destination_value, ifc.flags);
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h00E0);
    exp_q.push_back(16'h0000);
    got = ifc.pc; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL reset_pc got=%h want=%h", got, exp); fails++; end
    got = ifc.flags; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL reset_flags got=%h want=%h", got, exp); fails++; end
    got = ifc.banking; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL reset_banking got=%h want=%h", got, exp); fails++; end
    got = ifc.source_value; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL reset_source got=%h want=%h", got, exp); fails++; end
    reset = 1'b1;
    m_pc  = 16'h0000;
    $display("txn reset released");
  endtask

  task automatic test_pc_write();
    latch(4'h0, 4'h0, 1'b0);
    exp_q.push_back(16'hFFFF);
    commit(16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    got = ifc.pc; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL pc_write got=%h want=%h", got, exp); fails++; end
    latch(4'h0, 4'h0, 1'b0);
    exp_q.push_back(16'h0000);
    commit(16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    got = ifc.pc; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL pc_wrap got=%h want=%h", got, exp); fails++; end
  endtask

  task automatic test_reg_vs_mem();
    latch(4'h0, 4'h5, 1'b0);
    commit(16'hFFF1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    latch(4'h0, 4'h1, 1'b0);
    exp_q.push_back(16'hFFF1);
    exp_q.push_back(16'h0000);
    got = ifc.destination_value; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL r1_via_mem got=%h want=%h", got, exp); fails++; end
    got = {15'b0, ifc.destination_banked}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL r1_banked got=%h want=%h", got, exp); fails++; end
    exp_q.push_back(16'hFFF1);
    commit(16'h5555, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    got = ifc.destination_value; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL mem_write_ignored got=%h want=%h", got, exp); fails++; end
  endtask

  task automatic test_banked();
    for (int k = 0; k < 3; k++) begin
      latch(4'h0, 4'hD + 4'(k), 1'b0);
      commit(16'hFFF9 ^ 16'(k << 8), 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      latch(4'h0, 4'h9 + 4'(k), 1'b0);
      exp_q.push_back(16'hFFF9 ^ 16'(k << 8));
      exp_q.push_back(16'h0001);
      got = ifc.destination_value; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin $display("FAIL rb%0d_value got=%h want=%h", k + 1, got, exp); fails++; end
      got = {15'b0, ifc.destination_banked}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin $display("FAIL rb%0d_banked got=%h want=%h", k + 1, got, exp); fails++; end
    end
  endtask

  task automatic test_flags();
    latch(4'h0, 4'h8, 1'b0);
    exp_q.push_back(16'hFF00);
    commit(16'h5555, 1'b1, 1'b0, 1'b0, 16'hFF00, 1'b1);
    got = ifc.flags; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL flags_override got=%h want=%h", got, exp); fails++; end
    latch(4'h0, 4'h8, 1'b0);
    exp_q.push_back(16'h5555);
    commit(16'h5555, 1'b1, 1'b0, 1'b0, 16'hFF00, 1'b0);
    got = ifc.flags; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL flags_write got=%h want=%h", got, exp); fails++; end
    exp_q.push_back(m_pc);
    got = ifc.pc; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL pc_count got=%h want=%h", got, exp); fails++; end
  endtask

  task automatic test_stack();
    latch(4'h0, 4'h5, 1'b0);
    commit(16'h0010, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    latch(4'h0, 4'h1, 1'b1);
    exp_q.push_back(16'h000F);
    got = ifc.destination_value; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL push_dec got=%h want=%h", got, exp); fails++; end
    commit(16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    latch(4'h1, 4'h0, 1'b0);
    exp_q.push_back(16'h0010);
    commit(16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    got = ifc.source_value; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL pop_inc got=%h want=%h", got, exp); fails++; end
    latch(4'h4, 4'h1, 1'b0);
    exp_q.push_back(16'h0011);
    exp_q.push_back(16'h0000);
    commit(16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
    got = ifc.destination_value; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL dest_inc got=%h want=%h", got, exp); fails++; end
    got = ifc.source_value; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL imm_read got=%h want=%h", got, exp); fails++; end
    // Wrap-around both ways on r2.
    latch(4'h0, 4'h6, 1'b0);
    commit(16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    latch(4'h0, 4'h2, 1'b1);
    exp_q.push_back(16'hFFFF);
    got = ifc.destination_value; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL push_wrap got=%h want=%h", got, exp); fails++; end
    commit(16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    latch(4'h2, 4'h0, 1'b0);
    exp_q.push_back(16'h0000);
    commit(16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    got = ifc.source_value; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL pop_wrap got=%h want=%h", got, exp); fails++; end
  endtask

  task automatic test_back_to_back();
    // Immediate destination swallows writes.
    latch(4'h4, 4'h4, 1'b0);
    exp_q.push_back(16'h0000);
    commit(16'hABCD, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    got = ifc.destination_value; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL imm_write got=%h want=%h", got, exp); fails++; end
    // A register-mode write beats a pop of the same register.
    latch(4'h1, 4'h5, 1'b0);
    exp_q.push_back(16'h1234);
    commit(16'h1234, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    got = ifc.source_value; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL write_beats_pop got=%h want=%h", got, exp); fails++; end
    // Banking register write moves the banked flags.
    latch(4'h0, 4'hC, 1'b0);
    exp_q.push_back(16'h0002);
    commit(16'h0002, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    got = ifc.banking; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL bank_write got=%h want=%h", got, exp); fails++; end
    latch(4'h9, 4'h1, 1'b0);
    exp_q.push_back(16'h0001);
    exp_q.push_back(16'h0000);
    got = {15'b0, ifc.destination_banked}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL r1_banked_now got=%h want=%h", got, exp); fails++; end
    got = {15'b0, ifc.source_banked}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL rb1_unbanked got=%h want=%h", got, exp); fails++; end
    // Steps 0 and 2 hold state: only commits advance the PC.
    repeat (3) @(negedge clock);
    exp_q.push_back(m_pc);
    got = ifc.pc; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL pc_hold got=%h want=%h", got, exp); fails++; end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h00E0);
    got = ifc.pc; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL async_pc got=%h want=%h", got, exp); fails++; end
    got = ifc.banking; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin $display("FAIL async_banking got=%h want=%h", got, exp); fails++; end
    @(negedge clock);
    reset = 1'b1;
    m_pc  = 16'h0000;
    $display("txn async reset pulse");
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_pc_write();
    test_reg_vs_mem();
    test_banked();
    test_flags();
    test_stack();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
